// File: rtl/tile_fetch_seq.sv
// tile_fetch_seq: strided 2-D tile read sequencer feeding the systolic array
// Ports: clk/rst (sync, active-high); start + cfg_* launch a tile; busy/done report progress;
//        cmd_* issue single outstanding READs; rsp_* accept read data;
//        out_* stream each byte with row-end (out_last_row) and tile-end (out_last) markers.
module tile_fetch_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [DIM_WIDTH-1:0]  cfg_rows,
    input  logic [DIM_WIDTH-1:0]  cfg_cols,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_valid,
    output logic [1:0]            cmd_type,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_ready,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last_row,
    output logic                  out_last,
    input  logic                  out_ready
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, HOLD, DONE} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d, addr_q, addr_d, stride_q, stride_d;
    logic [DIM_WIDTH-1:0]  rows_q, rows_d, cols_q, cols_d, r_q, r_d, c_q, c_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  out_valid_q, out_valid_d, last_row_q, last_row_d, last_q, last_d;

    assign busy         = state_q inside {ISSUE, WAIT_RSP, HOLD};
    assign done         = state_q == DONE;
    assign cmd_valid    = state_q == ISSUE;
    assign cmd_type     = 2'b01;
    assign cmd_addr     = addr_q;
    assign cmd_data     = '0;
    assign rsp_ready    = (state_q == WAIT_RSP) && rsp_valid && !out_valid_q;
    assign out_valid    = out_valid_q;
    assign out_data     = data_q;
    assign out_last_row = last_row_q;
    assign out_last     = last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_base_q  <= '0;
            addr_q      <= '0;
            stride_q    <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            r_q         <= '0;
            c_q         <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            last_row_q  <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_base_q  <= row_base_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            r_q         <= r_d;
            c_q         <= c_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            last_row_q  <= last_row_d;
            last_q      <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_base_d  = row_base_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        r_d         = r_q;
        c_d         = c_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        last_row_d  = last_row_q;
        last_d      = last_q;
        case (state_q)
            IDLE: if (start) begin
                rows_d     = cfg_rows;
                cols_d     = cfg_cols;
                stride_d   = cfg_stride;
                row_base_d = cfg_base;
                addr_d     = cfg_base;
                r_d        = '0;
                c_d        = '0;
                // An empty tile passes through HOLD with nothing held, so done lands two cycles after start
                state_d    = (cfg_rows == '0 || cfg_cols == '0) ? HOLD : ISSUE;
            end
            ISSUE: if (cmd_ready) state_d = WAIT_RSP;
            WAIT_RSP: if (rsp_ready) begin
                data_d      = rsp_data;
                out_valid_d = 1'b1;
                last_row_d  = c_q == cols_q - DIM_WIDTH'(1);
                last_d      = (c_q == cols_q - DIM_WIDTH'(1)) && (r_q == rows_q - DIM_WIDTH'(1));
                state_d     = HOLD;
            end
            HOLD: begin
                if (!out_valid_q) begin
                    state_d = DONE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = last_q ? DONE : ISSUE;
                    if (!last_q && !last_row_q) begin
                        c_d    = c_q + DIM_WIDTH'(1);
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end else if (!last_q) begin
                        c_d        = '0;
                        r_d        = r_q + DIM_WIDTH'(1);
                        row_base_d = row_base_q + stride_q;
                        addr_d     = row_base_q + stride_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tile_fetch_seq.sv
// tb_tile_fetch_seq: scoreboard bench for tile_fetch_seq with a 2-cycle read-latency memory model
module tb_tile_fetch_seq;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] cfg_base = '0, cfg_stride = '0;
    logic [7:0]  cfg_rows = '0, cfg_cols = '0;
    logic        busy, done, cmd_valid, cmd_ready = 1'b1, rsp_valid, rsp_ready;
    logic [1:0]  cmd_type;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_data, rsp_data, out_data;
    logic        out_valid, out_last_row, out_last, out_ready = 1'b1;
    int          tests = 0, fails = 0, done_cnt = 0, out_cnt = 0;
    logic [15:0] cmd_q[$];
    logic [9:0]  out_q[$];
    logic        mdly;
    logic [15:0] paddr;

    always #5 clk = ~clk;

    tile_fetch_seq dut (
        .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_rows(cfg_rows),
        .cfg_cols(cfg_cols), .cfg_stride(cfg_stride), .busy(busy), .done(done),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last_row(out_last_row),
        .out_last(out_last), .out_ready(out_ready)
    );

    // Memory: data = addr[7:0], rsp_valid rises two cycles after command acceptance
    always @(posedge clk) begin
        if (rst) begin
            mdly      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            paddr     <= '0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            mdly <= cmd_valid && cmd_ready;
            if (cmd_valid && cmd_ready) paddr <= cmd_addr;
            if (mdly) begin
                rsp_valid <= 1'b1;
                rsp_data  <= paddr[7:0];
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        if (rsp_ready && !rsp_valid) begin
            fails++;
            $display("FAIL rsp_ready_without_valid: got 1 expected 0");
        end
        if (cmd_valid && cmd_ready) begin
            if (cmd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL cmd_unexpected: got %0h expected none", cmd_addr);
            end else chk("cmd_addr", {16'h0, cmd_addr}, {16'h0, cmd_q.pop_front()});
        end
        if (out_valid && out_ready) begin
            out_cnt++;
            if (out_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_unexpected: got %0h expected none", out_data);
            end else chk("out_beat", {22'h0, out_data, out_last_row, out_last}, {22'h0, out_q.pop_front()});
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_tile(input logic [15:0] b, input int rows, input int cols, input logic [15:0] s);
        logic [15:0] a;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                a = b + 16'(r) * s + 16'(c);
                cmd_q.push_back(a);
                out_q.push_back({a[7:0], c == cols - 1, (c == cols - 1) && (r == rows - 1)});
            end
    endtask

    task automatic launch(input logic [15:0] b, input int rows, input int cols, input logic [15:0] s);
        expect_tile(b, rows, cols, s);
        cfg_base   = b;
        cfg_rows   = 8'(rows);
        cfg_cols   = 8'(cols);
        cfg_stride = s;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (!done && c < 500) begin
            tick();
            c++;
        end
    endtask

    task automatic finish_tile(input string n, input int c, input int exp_c, input int d0);
        chk({n, "_done_cycle"}, c, exp_c);
        chk({n, "_busy_at_done"}, {31'h0, busy}, 0);
        tick();
        chk({n, "_done_pulse"}, {31'h0, done}, 0);
        chk({n, "_done_count"}, done_cnt - d0, 1);
        chk({n, "_drained"}, cmd_q.size() + out_q.size(), 0);
    endtask

    task automatic chk_reset(input string n);
        chk({n, "_flags"}, {25'h0, busy, done, cmd_valid, rsp_ready, out_valid, out_last_row, out_last}, 0);
        chk({n, "_addr_data"}, {8'h0, cmd_addr, out_data}, 0);
    endtask

    initial begin
        int c, d0, o0, k;
        logic [9:0] held;
        repeat (3) tick();
        chk_reset("rst_hold");
        rst = 1'b0;
        tick();
        chk_reset("rst_release");
        chk("cmd_consts", {22'h0, cmd_type, cmd_data}, {22'h0, 2'b01, 8'h00});

        // Basic 2x3 tile with per-element latency checks
        d0 = done_cnt;
        launch(16'h0100, 2, 3, 16'd16);
        chk("basic_c1", {29'h0, busy, cmd_valid, out_valid}, {29'h0, 3'b110});
        chk("basic_c1_addr", cmd_addr, 16'h0100);
        tick();
        chk("basic_c2", {30'h0, cmd_valid, rsp_ready}, 0);
        tick();
        chk("basic_c3_rsp", {30'h0, rsp_valid, rsp_ready}, 3);
        tick();
        chk("basic_c4_out", {22'h0, out_valid, out_data, cmd_valid}, {22'h0, 1'b1, 8'h00, 1'b0});
        tick();
        chk("basic_c5_cmd", {15'h0, cmd_valid, cmd_addr}, {15'h0, 1'b1, 16'h0101});
        wait_done(5, c);
        finish_tile("basic", c, 25, d0);

        // Address wrap past the top of memory
        d0 = done_cnt;
        launch(16'hFFFE, 1, 4, 16'd0);
        wait_done(1, c);
        finish_tile("wrap", c, 17, d0);

        // Zero-size tile: no traffic, done two cycles after start
        d0 = done_cnt;
        launch(16'h0500, 0, 5, 16'd4);
        chk("zero_c1", {29'h0, cmd_valid, out_valid, done}, 0);
        tick();
        chk("zero_c2", {29'h0, done, cmd_valid, out_valid}, {29'h0, 3'b100});
        finish_tile("zero", 2, 2, d0);

        // Backpressure on the first byte for 5 cycles
        d0 = done_cnt;
        out_ready = 1'b0;
        launch(16'h0300, 2, 2, 16'h0020);
        c = 1;
        while (!out_valid && c < 50) begin
            tick();
            c++;
        end
        chk("bp_first_out", c, 4);
        held = {out_data, out_last_row, out_last};
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {21'h0, out_valid, out_data, out_last_row, out_last}, {21'h0, 1'b1, held});
            chk("bp_quiet", {30'h0, rsp_ready, cmd_valid}, 0);
            tick();
            c++;
        end
        out_ready = 1'b1;
        wait_done(c, c);
        finish_tile("bp", c, 22, d0);

        // Command stall with an ignored start carrying a different config
        d0 = done_cnt;
        cmd_ready = 1'b0;
        launch(16'h0400, 2, 2, 16'd8);
        for (int i = 0; i < 4; i++) begin
            chk("stall_hold", {15'h0, cmd_valid, cmd_addr}, {15'h0, 1'b1, 16'h0400});
            start      = (i == 1);
            cfg_base   = 16'h0900;
            cfg_rows   = 8'd1;
            cfg_cols   = 8'd1;
            cfg_stride = 16'd3;
            tick();
        end
        cmd_ready = 1'b1;
        wait_done(5, c);
        finish_tile("stall", c, 21, d0);

        // Reset after three bytes, then a fresh tile at 0x0200
        launch(16'h0100, 2, 3, 16'd16);
        o0 = out_cnt;
        k  = 0;
        while (out_cnt < o0 + 3 && k < 100) begin
            tick();
            k++;
        end
        chk("mid_bytes", out_cnt - o0, 3);
        rst = 1'b1;
        tick();
        chk_reset("mid_rst");
        rst = 1'b0;
        cmd_q.delete();
        out_q.delete();
        tick();
        chk_reset("mid_idle");
        d0 = done_cnt;
        launch(16'h0200, 2, 3, 16'd16);
        chk("post_rst_addr", cmd_addr, 16'h0200);
        wait_done(1, c);
        finish_tile("post_rst", c, 25, d0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
